// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the IF/DM memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } arb_state_t;

    // dm_size encoding taken straight from func3[1:0]; 2'b11 decodes as word.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load lane select/extension
module lsu_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_zext,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    // Replicating the low bytes into every lane lets the byte enables alone pick the target.
    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (st_size)
            BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_lane;
            end
            HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << {st_lane[1], 1'b0};
            end
            default: ;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    assign ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            BYTE:    ld_data = {{24{~ld_zext & ld_byte[7]}}, ld_byte};
            HALF:    ld_data = {{16{~ld_zext & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stage
// MEMARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of fixed DM priority
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_size,
    input  logic        dm_sign,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    arb_state_t  state;
    logic [31:0] tmo_cnt;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic        lat_zext;
    logic        dm_pend;
    logic        grant_dm;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign dm_pend = dm_rd | dm_wr;

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_grant_if;
    assign grant_dm = dm_pend & (~if_req | last_grant_if);
`else
    assign grant_dm = dm_pend;
`endif

    lsu_align u_align (
        .st_size  (dm_size),
        .st_lane  (dm_addr[1:0]),
        .st_data  (dm_wdata),
        .st_wdata (st_wdata),
        .st_be    (st_be),
        .ld_size  (lat_size),
        .ld_lane  (lat_lane),
        .ld_zext  (lat_zext),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            lat_size    <= '0;
            lat_lane    <= '0;
            lat_zext    <= 1'b0;
            if_rdata    <= '0;
            if_valid    <= 1'b0;
            dm_rdata    <= '0;
            dm_valid    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            timeout_err <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_grant_if <= 1'b1;
`endif
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_dm) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_wr;
                        mem_addr  <= dm_addr & ~32'h3;
                        mem_wdata <= dm_wr ? st_wdata : '0;
                        mem_be    <= dm_wr ? st_be : 4'b1111;
                        lat_size  <= dm_size;
                        lat_lane  <= dm_addr[1:0];
                        lat_zext  <= dm_sign;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last_grant_if <= 1'b0;
`endif
                    end else if (if_req) begin
                        state     <= BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr & ~32'h3;
                        mem_wdata <= '0;
                        mem_be    <= 4'b1111;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last_grant_if <= 1'b1;
`endif
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!mem_we)
                                dm_rdata <= ld_data;
                            dm_valid <= 1'b1;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                        // Abort still completes the transaction so the stalled pipeline can move on.
                        state       <= RESP;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (state == BUSY_IF) begin
                            if_rdata <= ARB_ABORT_DATA;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= ARB_ABORT_DATA;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
